spi_regbank_burst: RTL and testbench
====================================

Name: spi_regbank_burst

Overview:
- Parametrised SPI slave register bank; successor to the current fixed 8-register SPI wrapper.
- Supports all four SPI modes, a configurable register width and count, and burst transfers with address auto-increment.
- Sits behind the top-level 2-stage synchronizers: every SPI input arrives already synchronised to clk.
- Exposes a flat config register vector (writable) and takes a flat status vector (read-only).

Parameters:
- NUM_CFG, 8, number of writable config registers (1..64).
- NUM_STATUS, 8, number of read-only status registers (1..64); NUM_CFG+NUM_STATUS <= 128.
- REG_WIDTH, 8, bits per register (4..32).
- CFG_RESET, 0, reset value applied to every config register (REG_WIDTH bits).

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- ena  in  1  when low, all state holds.
- mode  in  2  {cpol, cpha}, synchronised; sampled only while spi_cs_n is high.
- spi_cs_n  in  1  synchronised chip select, active low.
- spi_clk  in  1  synchronised SPI clock.
- spi_mosi  in  1  synchronised MOSI.
- spi_miso  out  1  MISO data.
- spi_miso_oe  out  1  MISO output enable = !spi_cs_n.
- config_regs  out  NUM_CFG*REG_WIDTH  config registers, reg i at bits [i*REG_WIDTH +: REG_WIDTH].
- status_regs  in  NUM_STATUS*REG_WIDTH  status registers, same packing.

Behaviour:
- Reset:
  - State IDLE; all config regs = CFG_RESET.
  - spi_miso=0, shift registers 0, address 0, spi_clk_d=0.
- Edge detection:
  - spi_clk_d registers spi_clk every enabled cycle.
  - Edges are decoded only while spi_cs_n=0.
  - Leading edge = rising if cpol=0, falling if cpol=1.
  - cpha=0: sample on leading edge, shift on trailing edge.
  - cpha=1: shift on leading edge, sample on trailing edge.
- Frame format, MSB first:
  - Command byte (8 bits): bit7 = 1 write / 0 read, bits[6:0] = start address.
  - Then any number of REG_WIDTH-bit data words.
- Address map:
  - 0..NUM_CFG-1 are config registers.
  - NUM_CFG..NUM_CFG+NUM_STATUS-1 are status registers.
  - Addresses above that range are unmapped.
- FSM IDLE -> CMD -> DATA:
  - IDLE: when spi_cs_n=0 go to CMD, latch mode, clear bit_cnt.
  - CMD: each sample edge shifts MOSI into rx and increments bit_cnt. On the 8th bit, latch rw and addr, clear bit_cnt, go to DATA.
  - DATA: on each REG_WIDTH-th sample edge the word is complete; clear bit_cnt.
    - Write frame: if addr < NUM_CFG, load the word into config reg[addr]; the register is visible on config_regs one clk after that sample edge is detected. Writes to status or unmapped addresses are dropped.
    - Then addr increments. After NUM_CFG+NUM_STATUS-1 it wraps to 0; this applies to both read and write.
  - Any state: spi_cs_n=1 -> IDLE next cycle. A partial word is discarded with no write, and spi_miso is driven 0.
- MISO:
  - spi_miso = MSB of the tx shift register.
  - On a shift edge, if bit_cnt==0, tx loads the next word; otherwise tx shifts left with 0 fill.
  - Loaded word in CMD or write-DATA: 0. In read-DATA: the register at the current addr, or 0 if unmapped.
  - For cpha=0 the MSB is therefore valid before the next leading edge.
  - Status is sampled at load time; no snapshot is taken across a burst.
- Edges while ena=0 are missed. The system clock must be at least 4x spi_clk.
- Reset mid-frame: immediate return to the reset state, regardless of spi_cs_n.
- mode changes while spi_cs_n=0 have no effect until the next frame.

Optional Feature:
- Macro SPI_REGBANK_WR_STROBE_EN.
- Defined: adds output port cfg_wr_strobe [NUM_CFG-1:0].
  - Bit i pulses high for exactly one clk in the same cycle config reg i updates.
  - The pulse fires even if the written value equals the old one.
  - Reset value 0.
- Undefined: port absent, no strobe logic.

Decomposition:
- Package spi_regbank_pkg holds:
  - state enum (IDLE, CMD, DATA);
  - CMD_WIDTH=8 and the RW_BIT index;
  - mode encoding constants (MODE0..MODE3).
- Sub-module spi_edge_detect: takes spi_clk, spi_cs_n and the latched mode; outputs single-cycle sample_edge and shift_edge. The bank owns the FSM, counters and registers.

Test Plan:
- Mode 0, write frame 0x80 then 0x3C, 0xA5 -> cfg[0]=0x3C, cfg[1]=0xA5; other regs stay at CFG_RESET.
- Mode 3, read frame 0x08 (status 0) with status_regs[7:0]=0xCA, then 2 words -> MISO returns 0xCA then status[1]=0x10; spi_miso_oe=1 only while CS low.
- Burst write from 0x87 with 3 words, defaults -> cfg[7] written, then addr 8..9 (status) writes dropped; next read frame from 0x7F returns 0x00, then wraps to addr 0 = cfg[0].
- Modes 1 and 2, write 0x82 then 0x5A -> cfg[2]=0x5A in each mode; MISO bit timing is correct per cpha.
- Abort: CS high after 5 bits of a data word -> no write, FSM in IDLE; the next frame works normally.
- REG_WIDTH=16, NUM_CFG=4, write 0x81 then 0xBEEF -> cfg[1]=0xBEEF; with SPI_REGBANK_WR_STROBE_EN, cfg_wr_strobe=4'b0010 for one cycle.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// ============================================================================
// Module   : spi_regbank_pkg
// Desc     : Shared types and constants for the burst SPI register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int CMD_WIDTH = 8;
    localparam int RW_BIT    = 7;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_regbank_burst_edge.sv
// ============================================================================
// Module   : spi_edge_detect
// Desc     : Turns the synchronised SPI clock into single-cycle sample/shift
//            strobes according to the latched {cpol, cpha}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_edge_detect
    import spi_regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic [1:0] mode,
    output logic       sample_edge,
    output logic       shift_edge
);

    logic r_spi_clk_d;
    logic w_rise;
    logic w_fall;
    logic w_leading;
    logic w_trailing;
    logic w_active;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_spi_clk_d <= 1'b0;
        end else if (ena) begin
            r_spi_clk_d <= spi_clk;
        end
    end

    assign w_rise     = spi_clk & ~r_spi_clk_d;
    assign w_fall     = ~spi_clk & r_spi_clk_d;
    assign w_leading  = mode[1] ? w_fall : w_rise;
    assign w_trailing = mode[1] ? w_rise : w_fall;
    assign w_active   = ena & ~spi_cs_n;

    assign sample_edge = w_active & (mode[0] ? w_trailing : w_leading);
    assign shift_edge  = w_active & (mode[0] ? w_leading : w_trailing);

endmodule

`default_nettype wire

// File: rtl/spi_regbank_burst.sv
// ============================================================================
// Module   : spi_regbank_burst
// Desc     : SPI slave register bank, all four modes, burst auto-increment.
//            Define SPI_REGBANK_WR_STROBE_EN to add the cfg_wr_strobe port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_regbank_burst
    import spi_regbank_pkg::*;
#(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter logic [REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic                             spi_miso_oe,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs
`ifdef SPI_REGBANK_WR_STROBE_EN
    ,
    output logic [NUM_CFG-1:0]               cfg_wr_strobe
`endif
);

    localparam int TOTAL = NUM_CFG + NUM_STATUS;
    localparam int RX_W  = (REG_WIDTH > CMD_WIDTH) ? REG_WIDTH : CMD_WIDTH;
    localparam int CNT_W = $clog2(RX_W + 1);

    state_t                 r_state;
    logic [1:0]             r_mode;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [RX_W-2:0]        r_rx;
    logic [REG_WIDTH-1:0]   r_tx;
    logic [6:0]             r_addr;
    logic                   r_rw;

    logic                   w_sample;
    logic                   w_shift;
    logic [RX_W-1:0]        w_rx_next;
    logic [CNT_W-1:0]       w_bit_cnt_inc;
    logic                   w_cmd_done;
    logic                   w_word_done;
    logic [6:0]             w_addr_next;
    logic [REG_WIDTH-1:0]   w_rd_word;
    logic [REG_WIDTH-1:0]   w_load_word;
    logic [NUM_CFG-1:0]     w_wr_hit;

    spi_edge_detect u_edge (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .mode        (r_mode),
        .sample_edge (w_sample),
        .shift_edge  (w_shift)
    );

    assign w_rx_next     = {r_rx, spi_mosi};
    assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
    assign w_cmd_done    = (r_state == CMD)  && w_sample && (w_bit_cnt_inc == CNT_W'(CMD_WIDTH));
    assign w_word_done   = (r_state == DATA) && w_sample && (w_bit_cnt_inc == CNT_W'(REG_WIDTH));
    assign w_addr_next   = ({1'b0, r_addr} == 8'(TOTAL - 1)) ? 7'd0 : r_addr + 7'd1;

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if ({1'b0, r_addr} == 8'(i)) w_rd_word = config_regs[i*REG_WIDTH +: REG_WIDTH];
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if ({1'b0, r_addr} == 8'(NUM_CFG + i)) w_rd_word = status_regs[i*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Only a read data phase returns register contents; command and write phases shift zeros.
    assign w_load_word = ((r_state == DATA) && !r_rw) ? w_rd_word : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= IDLE;
            r_mode    <= MODE0;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
        end else if (ena) begin
            if (spi_cs_n) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_rx      <= '0;
                r_tx      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= CMD;
                        r_mode    <= mode;
                        r_bit_cnt <= '0;
                    end
                    CMD, DATA: begin
                        if (w_sample) begin
                            r_rx <= w_rx_next[RX_W-2:0];
                            if (w_cmd_done) begin
                                r_rw      <= w_rx_next[RW_BIT];
                                r_addr    <= w_rx_next[6:0];
                                r_bit_cnt <= '0;
                                r_state   <= DATA;
                            end else if (w_word_done) begin
                                r_bit_cnt <= '0;
                                r_addr    <= w_addr_next;
                            end else begin
                                r_bit_cnt <= w_bit_cnt_inc;
                            end
                        end
                        if (w_shift) begin
                            r_tx <= (r_bit_cnt == '0) ? w_load_word : {r_tx[REG_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        logic [REG_WIDTH-1:0] r_reg;

        assign w_wr_hit[i] = w_word_done && r_rw && (r_addr == 7'(i));

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                r_reg <= CFG_RESET;
            end else if (w_wr_hit[i]) begin
                r_reg <= w_rx_next[REG_WIDTH-1:0];
            end
        end

        assign config_regs[i*REG_WIDTH +: REG_WIDTH] = r_reg;
    end

`ifdef SPI_REGBANK_WR_STROBE_EN
    logic [NUM_CFG-1:0] r_wr_strobe;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_strobe <= '0;
        end else begin
            r_wr_strobe <= w_wr_hit;
        end
    end

    assign cfg_wr_strobe = r_wr_strobe;
`endif

    assign spi_miso    = r_tx[REG_WIDTH-1];
    assign spi_miso_oe = ~spi_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_regbank_burst.sv
// ============================================================================
// Module   : tb_spi_regbank_burst
// Desc     : Self-checking bench: directed scenarios plus random bursts on an
//            8-bit and a 16-bit instance against an array-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_regbank_burst;
    import spi_regbank_pkg::*;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        cs_a = 1'b1;
    logic        cs_b = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        miso_a, miso_b, oe_a, oe_b;
    logic [63:0] cfg_a, cfg_b;
    logic [63:0] status_a = '0;
    logic [63:0] status_b = '0;
`ifdef SPI_REGBANK_WR_STROBE_EN
    logic [7:0]  strobe_a;
    logic [3:0]  strobe_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cfg_m [2][8];
    logic [15:0] st_m  [2][8];

    always #5 clk = ~clk;

    spi_regbank_burst dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
        .spi_cs_n(cs_a), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(miso_a), .spi_miso_oe(oe_a),
        .config_regs(cfg_a), .status_regs(status_a)
`ifdef SPI_REGBANK_WR_STROBE_EN
        , .cfg_wr_strobe(strobe_a)
`endif
    );

    spi_regbank_burst #(.NUM_CFG(4), .NUM_STATUS(4), .REG_WIDTH(16)) dut16 (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
        .spi_cs_n(cs_b), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(miso_b), .spi_miso_oe(oe_b),
        .config_regs(cfg_b), .status_regs(status_b)
`ifdef SPI_REGBANK_WR_STROBE_EN
        , .cfg_wr_strobe(strobe_b)
`endif
    );

`ifdef SPI_REGBANK_WR_STROBE_EN
    int          strobe_cycles = 0;
    logic [3:0]  strobe_last = '0;
    bit          strobe_chg = 1'b0;
    logic [63:0] cfg_b_prev = '0;
    always @(negedge clk) begin
        if (strobe_b != 4'd0) begin
            strobe_cycles++;
            strobe_last = strobe_b;
            strobe_chg  = (cfg_b !== cfg_b_prev);
        end
        cfg_b_prev = cfg_b;
    end
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_status();
        for (int i = 0; i < 8; i++) status_a[i*8 +: 8] = st_m[0][i][7:0];
        for (int i = 0; i < 4; i++) status_b[i*16 +: 16] = st_m[1][i];
    endtask

    // Master side: drives a whole frame MSB first, captures MISO where a master would.
    task automatic spi_xfer(input int sel, input logic [1:0] m, input int nbits,
                            input logic [127:0] txv, output logic [127:0] rxv, output bit oe_bad);
        rxv = '0;
        oe_bad = 1'b0;
        mode = m;
        spi_clk = m[1];
        spi_mosi = 1'b0;
        cyc(4);
        if (sel == 0) cs_a = 1'b0; else cs_b = 1'b0;
        cyc(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!m[0]) begin
                spi_mosi = txv[i];
                cyc(HALF);
                rxv[i] = (sel == 0) ? miso_a : miso_b;
                if (((sel == 0) ? oe_a : oe_b) !== 1'b1) oe_bad = 1'b1;
                spi_clk = ~spi_clk;
                cyc(HALF);
                spi_clk = ~spi_clk;
            end else begin
                spi_clk = ~spi_clk;
                spi_mosi = txv[i];
                cyc(HALF);
                rxv[i] = (sel == 0) ? miso_a : miso_b;
                if (((sel == 0) ? oe_a : oe_b) !== 1'b1) oe_bad = 1'b1;
                spi_clk = ~spi_clk;
                cyc(HALF);
            end
        end
        cyc(HALF);
        cs_a = 1'b1;
        cs_b = 1'b1;
        cyc(4);
    endtask

    // Reference: walks the burst address sequence, updates the model, returns expected MISO.
    function automatic logic [127:0] model_frame(input int sel, input bit rw, input int start,
                                                 input int n, input logic [127:0] data);
        int w   = (sel != 0) ? 16 : 8;
        int nc  = (sel != 0) ? 4 : 8;
        int tot = (sel != 0) ? 8 : 16;
        logic [127:0] expv = '0;
        logic [127:0] mask = (128'd1 << w) - 128'd1;
        logic [15:0]  word;
        int a = start;
        for (int k = 0; k < n; k++) begin
            word = 16'((data >> ((n - 1 - k) * w)) & mask);
            if (rw) begin
                if (a < nc) cfg_m[sel][a] = word;
            end else begin
                if (a < nc)       word = cfg_m[sel][a];
                else if (a < tot) word = st_m[sel][a - nc];
                else              word = 16'd0;
                expv |= 128'(word) << ((n - 1 - k) * w);
            end
            a = (a == tot - 1) ? 0 : (a + 1) % 128;
        end
        return expv;
    endfunction

    function automatic logic [63:0] exp_cfg(input int sel);
        logic [63:0] v = '0;
        if (sel == 0) for (int i = 0; i < 8; i++) v[i*8 +: 8] = cfg_m[0][i][7:0];
        else          for (int i = 0; i < 4; i++) v[i*16 +: 16] = cfg_m[1][i];
        return v;
    endfunction

    task automatic test_reset();
        rstb = 1'b0;
        cyc(3);
        n_checks++; if (cfg_a !== 64'd0) begin n_fail++; $display("FAIL reset_cfg8 got %h exp %h", cfg_a, 64'd0); end
        n_checks++; if (cfg_b !== 64'd0) begin n_fail++; $display("FAIL reset_cfg16 got %h exp %h", cfg_b, 64'd0); end
        n_checks++; if (miso_a !== 1'b0 || oe_a !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b/%b exp 0/0", miso_a, oe_a); end
`ifdef SPI_REGBANK_WR_STROBE_EN
        n_checks++; if (strobe_b !== 4'd0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0000", strobe_b); end
`endif
        rstb = 1'b1;
        cyc(2);
    endtask

    task automatic test_mode0_write();
        logic [127:0] rxv, expv;
        bit oe_bad;
        expv = model_frame(0, 1'b1, 0, 2, 128'h3CA5);
        spi_xfer(0, MODE0, 24, 128'h803CA5, rxv, oe_bad);
        n_checks++; if (cfg_a[15:0] !== 16'hA53C) begin n_fail++; $display("FAIL m0_write_cfg01 got %h exp a53c", cfg_a[15:0]); end
        n_checks++; if (cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL m0_write_all got %h exp %h", cfg_a, exp_cfg(0)); end
        n_checks++; if (rxv !== expv) begin n_fail++; $display("FAIL m0_write_miso got %h exp %h", rxv, expv); end
    endtask

    task automatic test_mode3_read();
        logic [127:0] rxv, expv;
        bit oe_bad;
        st_m[0][0] = 16'h00CA;
        st_m[0][1] = 16'h0010;
        apply_status();
        expv = model_frame(0, 1'b0, 8, 2, '0);
        spi_xfer(0, MODE3, 24, 128'h080000, rxv, oe_bad);
        n_checks++; if (rxv[23:0] !== 24'h00CA10) begin n_fail++; $display("FAIL m3_read_data got %h exp 00ca10", rxv[23:0]); end
        n_checks++; if (rxv !== expv) begin n_fail++; $display("FAIL m3_read_model got %h exp %h", rxv, expv); end
        n_checks++; if (oe_bad || oe_a !== 1'b0) begin n_fail++; $display("FAIL m3_oe got during=%0b after=%b exp during ok, after 0", !oe_bad, oe_a); end
    endtask

    task automatic test_burst_wrap();
        logic [127:0] rxv, expv;
        bit oe_bad;
        expv = model_frame(0, 1'b1, 7, 3, 128'h112233);
        spi_xfer(0, MODE0, 32, 128'h87112233, rxv, oe_bad);
        n_checks++; if (cfg_a[63:56] !== 8'h11) begin n_fail++; $display("FAIL burst_cfg7 got %h exp 11", cfg_a[63:56]); end
        n_checks++; if (cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL burst_all got %h exp %h", cfg_a, exp_cfg(0)); end
        expv = model_frame(0, 1'b0, 8, 2, '0);
        spi_xfer(0, MODE0, 24, 128'h080000, rxv, oe_bad);
        n_checks++; if (rxv !== expv) begin n_fail++; $display("FAIL burst_status_kept got %h exp %h", rxv, expv); end
        expv = model_frame(0, 1'b0, 127, 2, '0);
        spi_xfer(0, MODE0, 24, 128'h7F0000, rxv, oe_bad);
        n_checks++; if (rxv[15:0] !== {8'h00, 8'h3C}) begin n_fail++; $display("FAIL wrap_read got %h exp 003c", rxv[15:0]); end
        n_checks++; if (rxv !== expv) begin n_fail++; $display("FAIL wrap_model got %h exp %h", rxv, expv); end
    endtask

    task automatic test_modes12();
        logic [127:0] rxv, expv;
        bit oe_bad;
        for (int mi = 1; mi <= 2; mi++) begin
            expv = model_frame(0, 1'b1, 2, 1, 128'h00);
            spi_xfer(0, MODE0, 16, 128'h8200, rxv, oe_bad);
            expv = model_frame(0, 1'b1, 2, 1, 128'h5A);
            spi_xfer(0, 2'(mi), 16, 128'h825A, rxv, oe_bad);
            n_checks++; if (cfg_a[23:16] !== 8'h5A) begin n_fail++; $display("FAIL mode%0d_write got %h exp 5a", mi, cfg_a[23:16]); end
            expv = model_frame(0, 1'b0, 2, 1, '0);
            spi_xfer(0, 2'(mi), 16, 128'h0200, rxv, oe_bad);
            n_checks++; if (rxv[15:0] !== 16'h005A || rxv !== expv) begin n_fail++; $display("FAIL mode%0d_read got %h exp 005a", mi, rxv[15:0]); end
        end
    endtask

    task automatic test_abort();
        logic [127:0] rxv, expv;
        bit oe_bad;
        spi_xfer(0, MODE0, 13, {115'd0, 8'h83, 5'b10101}, rxv, oe_bad);
        n_checks++; if (cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL abort_nowrite got %h exp %h", cfg_a, exp_cfg(0)); end
        n_checks++; if (dut.r_state !== IDLE || miso_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle got state=%0d miso=%b exp 0/0", dut.r_state, miso_a); end
        expv = model_frame(0, 1'b1, 3, 1, 128'h77);
        spi_xfer(0, MODE1, 16, 128'h8377, rxv, oe_bad);
        n_checks++; if (cfg_a[31:24] !== 8'h77 || cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL abort_next got %h exp 77", cfg_a[31:24]); end
    endtask

    task automatic test_ena_hold();
        logic [127:0] rxv;
        bit oe_bad;
        ena = 1'b0;
        spi_xfer(0, MODE0, 16, 128'h80FF, rxv, oe_bad);
        ena = 1'b1;
        cyc(2);
        n_checks++; if (cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL ena_hold got %h exp %h", cfg_a, exp_cfg(0)); end
    endtask

    task automatic test_wide();
        logic [127:0] rxv, expv;
        bit oe_bad;
`ifdef SPI_REGBANK_WR_STROBE_EN
        int s0 = strobe_cycles;
`endif
        expv = model_frame(1, 1'b1, 1, 1, 128'hBEEF);
        spi_xfer(1, MODE0, 24, 128'h81BEEF, rxv, oe_bad);
        n_checks++; if (cfg_b[31:16] !== 16'hBEEF || cfg_b !== exp_cfg(1)) begin n_fail++; $display("FAIL wide_write got %h exp beef", cfg_b[31:16]); end
        n_checks++; if (cfg_a !== exp_cfg(0)) begin n_fail++; $display("FAIL wide_isolation got %h exp %h", cfg_a, exp_cfg(0)); end
`ifdef SPI_REGBANK_WR_STROBE_EN
        n_checks++;
        if (strobe_cycles - s0 != 1 || strobe_last !== 4'b0010 || !strobe_chg) begin
            n_fail++; $display("FAIL wide_strobe got cycles=%0d val=%b sync=%0b exp 1/0010/1", strobe_cycles - s0, strobe_last, strobe_chg);
        end
`endif
    endtask

    task automatic test_random();
        logic [127:0] rxv, expv, data, mask;
        bit oe_bad, rw;
        int sel, w, n, tot, addr;
        logic [1:0] m;
        for (int t = 0; t < 30; t++) begin
            sel  = $urandom_range(0, 1);
            w    = (sel != 0) ? 16 : 8;
            tot  = (sel != 0) ? 8 : 16;
            n    = (sel != 0) ? $urandom_range(1, 4) : $urandom_range(1, 6);
            rw   = 1'($urandom_range(0, 1));
            m    = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 127) : $urandom_range(0, tot + 2);
            mask = (128'd1 << w) - 128'd1;
            for (int i = 0; i < 8; i++) st_m[sel][i] = 16'($urandom) & 16'(mask);
            apply_status();
            data = '0;
            for (int k = 0; k < n; k++) data = (data << w) | (128'($urandom) & mask);
            expv = model_frame(sel, rw, addr, n, data);
            spi_xfer(sel, m, 8 + n * w, (128'({rw, 7'(addr)}) << (n * w)) | data, rxv, oe_bad);
            n_checks++; if (rxv !== expv) begin n_fail++; $display("FAIL rand%0d_miso sel=%0d got %h exp %h", t, sel, rxv, expv); end
            n_checks++;
            if ((sel == 0 && cfg_a !== exp_cfg(0)) || (sel != 0 && cfg_b !== exp_cfg(1))) begin
                n_fail++; $display("FAIL rand%0d_cfg sel=%0d got %h/%h exp %h/%h", t, sel, cfg_a, cfg_b, exp_cfg(0), exp_cfg(1));
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) for (int i = 0; i < 8; i++) begin cfg_m[s][i] = '0; st_m[s][i] = '0; end
        apply_status();
        test_reset();
        test_mode0_write();
        test_mode3_read();
        test_burst_wrap();
        test_modes12();
        test_abort();
        test_ena_hold();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
